// File: rtl/nn_operand_arbiter.sv
// -----------------------------------------------------------------------------
// nn_operand_arbiter
//
// Round-robin scheduler that shares one 3-input operand path between three
// requesters. It drives the 2-bit select of the shared operand mux and
// registers the selected word into a valid/ready stage that feeds the neuron
// MAC. A granted requester may stream up to MAX_BURST back-to-back beats
// before it has to give up the path.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   req[2:0]   bit i: requester i has a word on a(i+1)
//   a1/a2/a3   operand data of requesters 0/1/2
//   gnt[2:0]   combinational one-hot grant; the granted word is captured at
//              the next edge and the requester advances the cycle after
//   sel[1:0]   owner index to the operand mux, 2'b11 when idle
//   out_data   registered selected operand
//   out_valid  out_data holds a beat that has not been transferred
//   out_ready  downstream accepts the beat when out_valid & out_ready
//   busy       high while a requester owns the path
//
// state | meaning
// IDLE  | no owner; arbitrate among requests starting at ptr
// SERVE | owner's beat is held in the output stage; stream or release
// -----------------------------------------------------------------------------
module nn_operand_arbiter #(
    parameter int WIDTH     = 14,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] a3,
    output logic [2:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = $clog2(MAX_BURST) + 1;
    // beat_cnt + 1 < MAX_BURST is the same test as beat_cnt < MAX_BURST - 1
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t          state;
    logic [1:0]      owner;
    logic [1:0]      ptr;
    logic [CW-1:0]   beat_cnt;

    logic [1:0]      winner;
    logic [1:0]      cand;
    logic            found;
    logic            xfer;
    logic            cont;
    logic [WIDTH-1:0] win_data;
    logic [WIDTH-1:0] own_data;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [WIDTH-1:0] pick(input logic [1:0] i,
                                              input logic [WIDTH-1:0] d1,
                                              input logic [WIDTH-1:0] d2,
                                              input logic [WIDTH-1:0] d3);
        case (i)
            2'd0:    return d1;
            2'd1:    return d2;
            default: return d3;
        endcase
    endfunction

    // First set request scanning ptr, ptr+1, ptr+2 (mod 3)
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        cand   = ptr;
        for (int i = 0; i < 3; i++) begin
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
            cand = next_idx(cand);
        end
    end

    assign win_data = pick(winner, a1, a2, a3);
    assign own_data = pick(owner, a1, a2, a3);
    assign xfer     = out_valid & out_ready;
    // The owner keeps the path only if it still requests and has burst budget
    assign cont     = xfer & req[owner] & (beat_cnt < LAST_BEAT);

    always_comb begin
        gnt = 3'b000;
        if (!rst) begin
            if (state == IDLE && found)
                gnt = 3'b001 << winner;
            else if (state == SERVE && cont)
                gnt = 3'b001 << owner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 2'd0;
            ptr       <= 2'd0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sel       <= 2'b11;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        out_data  <= win_data;
                        out_valid <= 1'b1;
                        owner     <= winner;
                        beat_cnt  <= '0;
                        sel       <= winner;
                        busy      <= 1'b1;
                        state     <= SERVE;
                    end
                end
                SERVE: begin
                    if (xfer) begin
                        if (cont) begin
                            out_data <= own_data;
                            beat_cnt <= beat_cnt + 1'b1;
                        end else begin
                            out_valid <= 1'b0;
                            ptr       <= next_idx(owner);
                            sel       <= 2'b11;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_operand_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nn_operand_arbiter
//
// Drives two arbiters (MAX_BURST = 4 and MAX_BURST = 1) from the same inputs.
// A behavioural model of the scheduling rules tracks each one; directed tables
// and sequences add explicit expectations on top.
// -----------------------------------------------------------------------------
module tb_nn_operand_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [13:0] a1, a2, a3;
    logic        out_ready;

    logic [2:0]  gnt4, gnt1;
    logic [1:0]  sel4, sel1;
    logic [13:0] od4, od1;
    logic        ov4, ov1;
    logic        busy4, busy1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    nn_operand_arbiter #(.WIDTH(14), .MAX_BURST(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req), .a1(a1), .a2(a2), .a3(a3),
        .gnt(gnt4), .sel(sel4), .out_data(od4), .out_valid(ov4),
        .out_ready(out_ready), .busy(busy4)
    );

    nn_operand_arbiter #(.WIDTH(14), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .a1(a1), .a2(a2), .a3(a3),
        .gnt(gnt1), .sel(sel1), .out_data(od1), .out_valid(ov1),
        .out_ready(out_ready), .busy(busy1)
    );

    // ---------------- reference model (index 0: burst 4, index 1: burst 1)
    int mb [2] = '{4, 1};
    bit m_serve [2];
    int m_owner [2];
    int m_ptr   [2];
    int m_cnt   [2];
    bit m_valid [2];
    int m_data  [2];

    function automatic int a_of(input int i);
        case (i)
            0:       return int'(a1);
            1:       return int'(a2);
            default: return int'(a3);
        endcase
    endfunction

    function automatic int m_winner(input int k);
        for (int i = 0; i < 3; i++) begin
            int idx = (m_ptr[k] + i) % 3;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int m_exp_gnt(input int k);
        int w;
        if (rst) return 0;
        if (!m_serve[k]) begin
            w = m_winner(k);
            return (w >= 0) ? (1 << w) : 0;
        end
        if (out_ready && req[m_owner[k]] && (m_cnt[k] + 1 < mb[k]))
            return 1 << m_owner[k];
        return 0;
    endfunction

    task automatic m_reset(input int k);
        m_serve[k] = 0; m_owner[k] = 0; m_ptr[k] = 0;
        m_cnt[k] = 0;   m_valid[k] = 0; m_data[k] = 0;
    endtask

    task automatic m_update(input int k);
        int w;
        w = m_winner(k);
        if (rst) begin
            m_reset(k);
        end else if (!m_serve[k]) begin
            if (w >= 0) begin
                m_data[k] = a_of(w); m_valid[k] = 1; m_owner[k] = w;
                m_cnt[k] = 0; m_serve[k] = 1;
            end
        end else if (out_ready) begin
            if (req[m_owner[k]] && (m_cnt[k] + 1 < mb[k])) begin
                m_data[k] = a_of(m_owner[k]);
                m_cnt[k]++;
            end else begin
                m_valid[k] = 0;
                m_ptr[k] = (m_owner[k] + 1) % 3;
                m_serve[k] = 0;
            end
        end
    endtask

    // ---------------- checking helpers
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic cmp_dut(input int k, input logic [2:0] g, input logic [1:0] s,
                           input logic v, input logic [13:0] d, input logic b);
        chk($sformatf("m%0d gnt", k),  32'(g), 32'(m_exp_gnt(k)));
        chk($sformatf("m%0d sel", k),  32'(s), m_serve[k] ? 32'(m_owner[k]) : 32'd3);
        chk($sformatf("m%0d valid", k), 32'(v), 32'(m_valid[k]));
        chk($sformatf("m%0d busy", k), 32'(b), 32'(m_serve[k]));
        if (m_valid[k])
            chk($sformatf("m%0d data", k), 32'(d), 32'(m_data[k]));
    endtask

    // Apply one cycle of inputs, compare both DUTs with the model before the
    // edge, then advance the model across the edge.
    task automatic step(input logic r, input logic [2:0] rq, input logic [13:0] x1,
                        input logic [13:0] x2, input logic [13:0] x3, input logic rd);
        @(negedge clk);
        rst = r; req = rq; a1 = x1; a2 = x2; a3 = x3; out_ready = rd;
        #1;
        cmp_dut(0, gnt4, sel4, ov4, od4, busy4);
        cmp_dut(1, gnt1, sel1, ov1, od1, busy1);
        m_update(0);
        m_update(1);
    endtask

    // ---------------- directed table (explicit expectations for burst-4 DUT)
    typedef struct {
        logic        r;
        logic [2:0]  rq;
        logic [13:0] x1;
        logic        rd;
        logic [2:0]  g;
        logic [1:0]  s;
        logic        v;
        logic        chkd;
        logic [13:0] d;
        logic        b;
    } vec_t;

    vec_t tbl [6];

    int bst_g [7];
    int bst_v [7];
    int bst_d [7];
    int bst_s [7];
    int rr_q  [$];

    initial begin
        rst = 1'b1; req = 3'b000; a1 = '0; a2 = '0; a3 = '0; out_ready = 1'b0;
        m_reset(0); m_reset(1);
        repeat (2) @(posedge clk);

        // reset held with a pending request, then a single requester
        tbl[0] = '{1'b1, 3'b001, 14'h0123, 1'b1, 3'b000, 2'd3, 1'b0, 1'b1, 14'h0000, 1'b0};
        tbl[1] = '{1'b1, 3'b001, 14'h0123, 1'b1, 3'b000, 2'd3, 1'b0, 1'b1, 14'h0000, 1'b0};
        tbl[2] = '{1'b0, 3'b001, 14'h0123, 1'b1, 3'b001, 2'd3, 1'b0, 1'b1, 14'h0000, 1'b0};
        tbl[3] = '{1'b0, 3'b001, 14'h0124, 1'b1, 3'b001, 2'd0, 1'b1, 1'b1, 14'h0123, 1'b1};
        tbl[4] = '{1'b0, 3'b000, 14'h0124, 1'b1, 3'b000, 2'd0, 1'b1, 1'b1, 14'h0124, 1'b1};
        tbl[5] = '{1'b0, 3'b000, 14'h0124, 1'b1, 3'b000, 2'd3, 1'b0, 1'b0, 14'h0000, 1'b0};
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].r, tbl[i].rq, tbl[i].x1, 14'h0, 14'h0, tbl[i].rd);
            chk($sformatf("tbl%0d gnt", i),   32'(gnt4),  32'(tbl[i].g));
            chk($sformatf("tbl%0d sel", i),   32'(sel4),  32'(tbl[i].s));
            chk($sformatf("tbl%0d valid", i), 32'(ov4),   32'(tbl[i].v));
            chk($sformatf("tbl%0d busy", i),  32'(busy4), 32'(tbl[i].b));
            if (tbl[i].chkd)
                chk($sformatf("tbl%0d data", i), 32'(od4), 32'(tbl[i].d));
        end

        // burst limit: requester 1 streams 5,6,7,8, bubble, then re-granted
        bst_g = '{2, 2, 2, 2, 0, 2, 0};
        bst_v = '{0, 1, 1, 1, 1, 0, 1};
        bst_d = '{0, 5, 6, 7, 8, 0, 9};
        bst_s = '{3, 1, 1, 1, 1, 3, 1};
        begin
            logic [13:0] a2v;
            a2v = 14'd5;
            for (int c = 0; c < 7; c++) begin
                step(1'b0, (c < 6) ? 3'b010 : 3'b000, 14'h0, a2v, 14'h0, 1'b1);
                chk($sformatf("burst%0d gnt", c),   32'(gnt4), 32'(bst_g[c]));
                chk($sformatf("burst%0d valid", c), 32'(ov4),  32'(bst_v[c]));
                chk($sformatf("burst%0d sel", c),   32'(sel4), 32'(bst_s[c]));
                if (bst_v[c] == 1)
                    chk($sformatf("burst%0d data", c), 32'(od4), 32'(bst_d[c]));
                if (gnt4[1]) a2v = a2v + 14'd1;
            end
            step(1'b0, 3'b000, 14'h0, a2v, 14'h0, 1'b1);
            chk("burst end valid", 32'(ov4), 32'd0);
        end

        // round robin on the burst-1 arbiter
        step(1'b1, 3'b000, 14'h0, 14'h0, 14'h0, 1'b1);
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 3'b111, 14'(16'h100 + c), 14'(16'h200 + c), 14'(16'h300 + c), 1'b1);
            chk($sformatf("rr%0d valid", c), 32'(ov1), 32'(c % 2));
            if (ov1) rr_q.push_back(int'(sel1));
        end
        chk("rr count", 32'(rr_q.size()), 32'd6);
        for (int i = 0; i < rr_q.size(); i++)
            chk($sformatf("rr owner%0d", i), 32'(rr_q[i]), 32'(i % 3));

        // backpressure on requester 2
        step(1'b1, 3'b000, 14'h0, 14'h0, 14'h0, 1'b0);
        step(1'b0, 3'b100, 14'h0, 14'h0, 14'h3FFF, 1'b0);
        chk("bp grant", 32'(gnt4), 32'h4);
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 3'b011, 14'h0011, 14'h0022, 14'h0000, 1'b0);
            chk($sformatf("bp%0d gnt", c),   32'(gnt4), 32'h0);
            chk($sformatf("bp%0d valid", c), 32'(ov4),  32'h1);
            chk($sformatf("bp%0d data", c),  32'(od4),  32'h3FFF);
            chk($sformatf("bp%0d sel", c),   32'(sel4), 32'h2);
        end
        step(1'b0, 3'b000, 14'h0, 14'h0, 14'h0, 1'b1);
        chk("bp xfer data", 32'(od4), 32'h3FFF);
        chk("bp xfer gnt", 32'(gnt4), 32'h0);
        step(1'b0, 3'b000, 14'h0, 14'h0, 14'h0, 1'b1);
        chk("bp after valid", 32'(ov4), 32'h0);
        chk("bp after sel", 32'(sel4), 32'h3);

        // early withdrawal by requester 0 (ptr is 0 after requester 2 released)
        step(1'b0, 3'b001, 14'd10, 14'h0, 14'h0, 1'b1);
        chk("wd grant0", 32'(gnt4), 32'h1);
        step(1'b0, 3'b001, 14'd11, 14'h0, 14'h0, 1'b1);
        chk("wd beat0", 32'(od4), 32'd10);
        chk("wd grant1", 32'(gnt4), 32'h1);
        step(1'b0, 3'b000, 14'd12, 14'h0, 14'h0, 1'b0);
        chk("wd held data", 32'(od4), 32'd11);
        chk("wd held valid", 32'(ov4), 32'h1);
        chk("wd held gnt", 32'(gnt4), 32'h0);
        step(1'b0, 3'b000, 14'd12, 14'h0, 14'h0, 1'b1);
        chk("wd deliver data", 32'(od4), 32'd11);
        chk("wd deliver gnt", 32'(gnt4), 32'h0);
        step(1'b0, 3'b011, 14'h0AA, 14'h222, 14'h0, 1'b1);
        chk("wd idle valid", 32'(ov4), 32'h0);
        chk("wd ptr1 gnt", 32'(gnt4), 32'h2);

        // reset while a beat is held under backpressure
        step(1'b1, 3'b011, 14'h0AA, 14'h333, 14'h0, 1'b0);
        chk("rst held valid", 32'(ov4), 32'h1);
        chk("rst gnt", 32'(gnt4), 32'h0);
        step(1'b0, 3'b111, 14'h0AA, 14'h333, 14'h0, 1'b0);
        chk("post rst valid", 32'(ov4), 32'h0);
        chk("post rst sel", 32'(sel4), 32'h3);
        chk("post rst gnt", 32'(gnt4), 32'h1);
        step(1'b0, 3'b000, 14'h0, 14'h0, 14'h0, 1'b1);
        chk("post rst data", 32'(od4), 32'h0AA);
        chk("post rst owner", 32'(sel4), 32'h0);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 63) == 0),
                 3'($urandom_range(0, 7)),
                 14'($urandom), 14'($urandom), 14'($urandom),
                 ($urandom_range(0, 3) != 0));
            chk("gnt onehot", 32'($onehot0(gnt4) && $onehot0(gnt1)), 32'h1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
